uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver with a configurable frame format, per-frame error detection and an integrated receive FIFO. It replaces the bare receiver in the FPGA top level. It decouples the serial line from consumers such as the LED and hex-display logic and the planned APB3 register bank, using a valid/ready pop interface. Overflow is reported by a sticky flag rather than by silently losing data.

## Interface
Parameters:
- CLK_HZ, 10_000_000, system clock frequency in Hz
- BIT_RATE, 115200, serial bit rate; CYCLES_PER_BIT = CLK_HZ/BIT_RATE (integer division), HALF_BIT = CYCLES_PER_BIT/2
- PAYLOAD_BITS, 8, data bits per frame, legal range 5..9
- STOP_BITS, 1, stop bits per frame, 1 or 2
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even
- FIFO_DEPTH, 4, receive FIFO entries, power of two, at least 2

Ports:
- clk  in  1  system clock, all logic on the rising edge
- resetn  in  1  asynchronous, active-low reset
- uart_rxd  in  1  serial input, asynchronous to clk, idles high
- rx_data  out  PAYLOAD_BITS  payload of the FIFO head entry
- rx_parity_err  out  1  parity error flag of the head entry
- rx_frame_err  out  1  stop-bit error flag of the head entry
- rx_valid  out  1  FIFO non-empty; head entry is presented on the outputs
- rx_ready  in  1  consumer accepts the head entry
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of entries currently stored
- overflow  out  1  sticky: a completed frame was dropped because the FIFO was full
- clr_overflow  in  1  synchronous clear of overflow

## Operation
- uart_rxd passes through a 2-flop synchroniser whose flops reset to 1. Every mention of "line" below means the synchronised value.
- Receiver FSM states: IDLE, START, DATA, PAR, STOP. One bit-timing counter, one bit index and one shift register.
- IDLE: a 1-to-0 transition on the line moves the FSM to START and clears the counter. A line that is low when the FSM enters IDLE is ignored until it returns high.
- START: the line is sampled when the counter reaches HALF_BIT-1.
  - Sample 1: false start, return to IDLE.
  - Sample 0: go to DATA and clear the counter.
- DATA: the line is sampled every CYCLES_PER_BIT cycles, LSB first. After PAYLOAD_BITS samples the FSM goes to PAR if PARITY≠0, otherwise to STOP.
- PAR: one bit is sampled. parity_err is set when XOR(data, parity bit) = 0 for odd mode, or = 1 for even mode.
- STOP: STOP_BITS bits are sampled. If any stop sample is 0, frame_err is set.
  - In the cycle of the last stop sample, {frame_err, parity_err, data} is pushed into the FIFO and the FSM returns to IDLE.
  - This allows back-to-back frames whose next start edge arrives half a bit later.
- Frames with errors are still pushed, with their flags set.
- FIFO behaviour:
  - First-word-fall-through, implemented as a circular buffer with wrapping read and write pointers.
  - Pop occurs when rx_valid && rx_ready; rx_ready is ignored while rx_valid=0.
  - Push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - In every other full case the frame is dropped, overflow is set, and the FIFO contents are unchanged.
  - clr_overflow clears overflow. If a drop happens in the same cycle as clr_overflow, the flag stays set.
- Reset values: rx_data 0, rx_parity_err 0, rx_frame_err 0, rx_valid 0, fifo_count 0, overflow 0. FSM resets to IDLE. Pointers reset to 0.
- Reset asserted mid-frame discards the partial frame and all FIFO contents.

## Timing
- Input latency: 2 clk cycles through the synchroniser.
- From the line falling edge, the start bit is sampled after HALF_BIT cycles. Each later bit is sampled CYCLES_PER_BIT cycles after the previous one, at the nominal bit centre.
- rx_valid, rx_data and the flags update in the cycle after the push cycle when the FIFO was empty.
- After a pop, the next head entry appears in the following cycle, or rx_valid drops in that cycle if the FIFO is now empty.
- fifo_count updates one cycle after the push/pop event. A simultaneous push and pop leaves fifo_count unchanged.

## Structure
- Package uart_pkg contains:
  - parity mode constants PAR_NONE, PAR_ODD, PAR_EVEN
  - FSM state encoding
  - cycles-per-bit calculation function
  - FIFO entry width, PAYLOAD_BITS+2
- Sub-module sync_fifo (parameters WIDTH, DEPTH) provides first-word-fall-through storage with full, empty and count outputs. uart_rx_fifo contains the synchroniser, the FSM and the overflow logic.

## Test plan
All tests use CLK_HZ=10 MHz and BIT_RATE=115200, so CYCLES_PER_BIT=86 and HALF_BIT=43.
1. PARITY=0, send 0xA5 with rx_ready=1 -> rx_valid pulses for exactly 1 cycle with rx_data=0xA5, both error flags 0, and fifo_count returns to 0.
2. PARITY=2, send 0x07 with parity bit 0 -> an entry with rx_data=0x07 and rx_parity_err=1. Repeating with parity bit 1 -> rx_parity_err=0.
3. Send 0x3C with the stop bit driven 0, then a good 0x55 -> first entry has rx_data=0x3C and rx_frame_err=1; second has rx_data=0x55 with both flags 0.
4. A 20-cycle low glitch on uart_rxd -> no entry pushed, FSM returns to IDLE, and a following 0x81 frame is received correctly.
5. FIFO_DEPTH=4 and rx_ready=0, send 0x01..0x05 back to back -> fifo_count=4 and overflow=1. Popping returns 0x01..0x04 in order, then rx_valid=0. A clr_overflow pulse -> overflow=0.
6. resetn low for 3 cycles during bit 4 of a frame -> all outputs at their reset values and the FIFO empty. The next full frame 0xF0 is received with both flags 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared parity modes, receiver state encoding and sizing helpers
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} rx_state_t;
  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction
  function automatic int entry_width(input int payload_bits);
    return payload_bits + 2;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through circular buffer with wrapping pointers
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_din,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_wr, w_rd;
  assign o_full  = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
  assign w_rd    = i_pop & ~o_empty;
  // a full buffer still takes a write when the head leaves in the same cycle
  assign w_wr    = i_push & (~o_full | w_rd);
  assign o_dout  = o_empty ? '0 : r_mem[r_rptr];
  assign o_count = r_count;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(w_wr);
      r_rptr  <= r_rptr + AW'(w_rd);
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
    end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wptr] <= i_din;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with configurable framing, error flags and a receive FIFO
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 10_000_000,
  parameter int BIT_RATE     = 115200,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          uart_rxd,
  output logic [PAYLOAD_BITS-1:0]       rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_overflow
);
  localparam int CPB  = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int HALF = CPB / 2;
  localparam int EW   = entry_width(PAYLOAD_BITS);
  localparam int TW   = $clog2(CPB + 1);
  localparam int IW   = $clog2(PAYLOAD_BITS + 1);
  logic [1:0]              r_sync;
  logic                    r_prev, w_line, w_fall, w_tick;
  rx_state_t               r_state, w_state_nxt;
  logic [TW-1:0]           r_cnt, w_cnt_nxt;
  logic [IW-1:0]           r_idx, w_idx_nxt;
  logic [PAYLOAD_BITS-1:0] r_shift, w_shift_nxt;
  logic                    r_perr, w_perr_nxt, r_ferr, w_ferr_nxt;
  logic                    w_push, w_full, w_empty, w_drop, r_ovf;
  logic [EW-1:0]           w_entry, w_dout;
  assign w_line = r_sync[1];
  assign w_fall = r_prev & ~w_line;
  assign w_tick = r_cnt == TW'(CPB - 1);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_sync  <= 2'b11;
      r_prev  <= 1'b1;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], uart_rxd};
      r_prev  <= w_line;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_perr  <= w_perr_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + TW'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_perr_nxt  = r_perr;
    w_ferr_nxt  = r_ferr;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = w_fall ? S_START : S_IDLE;
      end
      S_START:
        if (r_cnt == TW'(HALF - 1)) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_perr_nxt  = 1'b0;
          w_ferr_nxt  = 1'b0;
          w_state_nxt = w_line ? S_IDLE : S_DATA;
        end
      S_DATA:
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_line, r_shift[PAYLOAD_BITS-1:1]};
          w_idx_nxt   = r_idx + IW'(1);
          if (r_idx == IW'(PAYLOAD_BITS - 1)) begin
            w_idx_nxt   = '0;
            w_state_nxt = (PARITY != PAR_NONE) ? S_PAR : S_STOP;
          end
        end
      S_PAR:
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_perr_nxt  = ((^r_shift) ^ w_line) == (PARITY == PAR_EVEN);
          w_state_nxt = S_STOP;
        end
      S_STOP:
        if (w_tick) begin
          w_cnt_nxt  = '0;
          w_ferr_nxt = r_ferr | ~w_line;
          w_idx_nxt  = r_idx + IW'(1);
          if (r_idx == IW'(STOP_BITS - 1)) begin
            w_push      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      default: w_state_nxt = S_IDLE;
    endcase
  end
  // the last stop sample is folded in combinationally so the push needs no extra cycle
  assign w_entry = {w_ferr_nxt, r_perr, r_shift};
  sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_din   (w_entry),
    .i_pop   (rx_ready),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );
  assign rx_valid = ~w_empty;
  assign {rx_frame_err, rx_parity_err, rx_data} = w_dout;
  assign w_drop   = w_push & w_full & ~(rx_valid & rx_ready);
  assign overflow = r_ovf;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_ovf <= 1'b0;
    else         r_ovf <= (r_ovf & ~clr_overflow) | w_drop;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized self-checking bench against a frame-level queue model
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int CPB   = 10_000_000 / 115200;
  localparam int DEPTH = 4;
  logic clk = 1'b0, resetn, line, sel, rdy, clr;
  logic rxd_a, rxd_b;
  logic [7:0] data_a, data_b;
  logic perr_a, perr_b, ferr_a, ferr_b, valid_a, valid_b, ovf_a, ovf_b;
  logic [2:0] cnt_a, cnt_b;
  logic [9:0] exp_a[$], exp_b[$], got_a[$], got_b[$];
  int vcyc_a, n_chk, n_pass;
  always #50 clk = ~clk;
  assign rxd_a = sel ? 1'b1 : line;
  assign rxd_b = sel ? line : 1'b1;
  uart_rx_fifo #(.CLK_HZ(10_000_000), .BIT_RATE(115200), .PAYLOAD_BITS(8), .STOP_BITS(1),
                 .PARITY(0), .FIFO_DEPTH(DEPTH)) u_dut_a (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd_a), .rx_data(data_a), .rx_parity_err(perr_a),
    .rx_frame_err(ferr_a), .rx_valid(valid_a), .rx_ready(rdy), .fifo_count(cnt_a),
    .overflow(ovf_a), .clr_overflow(clr));
  uart_rx_fifo #(.CLK_HZ(10_000_000), .BIT_RATE(115200), .PAYLOAD_BITS(8), .STOP_BITS(1),
                 .PARITY(2), .FIFO_DEPTH(DEPTH)) u_dut_b (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd_b), .rx_data(data_b), .rx_parity_err(perr_b),
    .rx_frame_err(ferr_b), .rx_valid(valid_b), .rx_ready(rdy), .fifo_count(cnt_b),
    .overflow(ovf_b), .clr_overflow(clr));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (valid_a) vcyc_a++;
      if (valid_a && rdy) got_a.push_back({ferr_a, perr_a, data_a});
      if (valid_b && rdy) got_b.push_back({ferr_b, perr_b, data_b});
    end
  endtask

  // model entry: frame error when stop is 0; even-parity error when data^parity has odd weight
  task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb);
    logic [9:0] e;
    e = {~sb, sel & ((^d) ^ pb), d};
    if (sel) exp_b.push_back(e); else exp_a.push_back(e);
    line = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      line = d[i];
      tick(CPB);
    end
    if (sel) begin
      line = pb;
      tick(CPB);
    end
    line = sb;
    tick(CPB);
    line = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(3);
    n_chk++; if ({valid_a, cnt_a, ovf_a, data_a, perr_a, ferr_a} !== 15'd0)
      $display("FAIL reset_a got %h want 0", {valid_a, cnt_a, ovf_a, data_a, perr_a, ferr_a}); else n_pass++;
    n_chk++; if ({valid_b, cnt_b, ovf_b, data_b, perr_b, ferr_b} !== 15'd0)
      $display("FAIL reset_b got %h want 0", {valid_b, cnt_b, ovf_b, data_b, perr_b, ferr_b}); else n_pass++;
    resetn = 1'b1;
    tick(5);
  endtask

  task automatic test_single();
    int v0;
    sel = 1'b0; rdy = 1'b1; v0 = vcyc_a;
    send_frame(8'hA5, 1'b0, 1'b1);
    tick(100);
    n_chk++; if (vcyc_a - v0 !== 1) $display("FAIL single_valid_cycles got %0d want 1", vcyc_a - v0); else n_pass++;
    n_chk++; if (got_a.size() !== 1) $display("FAIL single_count got %0d want 1", got_a.size()); else n_pass++;
    n_chk++; if (got_a.size() == 1 && got_a[0] !== 10'h0A5) $display("FAIL single_data got %h want 0a5", got_a[0]); else n_pass++;
    n_chk++; if (cnt_a !== 3'd0) $display("FAIL single_fifo_count got %0d want 0", cnt_a); else n_pass++;
    got_a.delete(); exp_a.delete();
  endtask

  task automatic test_parity();
    sel = 1'b1; rdy = 1'b1;
    send_frame(8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1);
    tick(100);
    n_chk++; if (got_b.size() !== 2) $display("FAIL parity_count got %0d want 2", got_b.size()); else n_pass++;
    for (int i = 0; i < 2 && i < got_b.size(); i++) begin
      n_chk++; if (got_b[i] !== exp_b[i]) $display("FAIL parity_entry%0d got %h want %h", i, got_b[i], exp_b[i]); else n_pass++;
    end
    n_chk++; if (got_b.size() > 0 && got_b[0][8] !== 1'b1) $display("FAIL parity_err_flag got %b want 1", got_b[0][8]); else n_pass++;
    got_b.delete(); exp_b.delete();
  endtask

  task automatic test_frame_err();
    sel = 1'b0; rdy = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(CPB);
    send_frame(8'h55, 1'b0, 1'b1);
    tick(100);
    n_chk++; if (got_a.size() !== 2) $display("FAIL frame_count got %0d want 2", got_a.size()); else n_pass++;
    for (int i = 0; i < 2 && i < got_a.size(); i++) begin
      n_chk++; if (got_a[i] !== exp_a[i]) $display("FAIL frame_entry%0d got %h want %h", i, got_a[i], exp_a[i]); else n_pass++;
    end
    got_a.delete(); exp_a.delete();
  endtask

  task automatic test_glitch();
    int v0;
    sel = 1'b0; rdy = 1'b1; v0 = vcyc_a;
    line = 1'b0;
    tick(20);
    line = 1'b1;
    tick(200);
    n_chk++; if (vcyc_a !== v0) $display("FAIL glitch_push got %0d want %0d", vcyc_a, v0); else n_pass++;
    send_frame(8'h81, 1'b0, 1'b1);
    tick(100);
    n_chk++; if (got_a.size() !== 1) $display("FAIL glitch_after_count got %0d want 1", got_a.size()); else n_pass++;
    n_chk++; if (got_a.size() == 1 && got_a[0] !== exp_a[0]) $display("FAIL glitch_after_data got %h want %h", got_a[0], exp_a[0]); else n_pass++;
    got_a.delete(); exp_a.delete();
  endtask

  task automatic test_back_to_back();
    sel = 1'b0; rdy = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1);
    while (exp_a.size() > DEPTH) void'(exp_a.pop_back());
    tick(100);
    n_chk++; if (cnt_a !== 3'(exp_a.size())) $display("FAIL b2b_fifo_count got %0d want %0d", cnt_a, exp_a.size()); else n_pass++;
    n_chk++; if (ovf_a !== 1'b1) $display("FAIL b2b_overflow got %b want 1", ovf_a); else n_pass++;
    n_chk++; if (valid_a !== 1'b1 || data_a !== 8'h01) $display("FAIL b2b_head got %b/%h want 1/01", valid_a, data_a); else n_pass++;
    rdy = 1'b1;
    tick(20);
    rdy = 1'b0;
    n_chk++; if (got_a.size() !== exp_a.size()) $display("FAIL b2b_pop_count got %0d want %0d", got_a.size(), exp_a.size()); else n_pass++;
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      n_chk++; if (got_a[i] !== exp_a[i]) $display("FAIL b2b_entry%0d got %h want %h", i, got_a[i], exp_a[i]); else n_pass++;
    end
    n_chk++; if (valid_a !== 1'b0) $display("FAIL b2b_drained got %b want 0", valid_a); else n_pass++;
    n_chk++; if (ovf_a !== 1'b1) $display("FAIL b2b_sticky got %b want 1", ovf_a); else n_pass++;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(1);
    n_chk++; if (ovf_a !== 1'b0) $display("FAIL b2b_clr_overflow got %b want 0", ovf_a); else n_pass++;
    got_a.delete(); exp_a.delete();
  endtask

  task automatic test_mid_reset();
    sel = 1'b0; rdy = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1);
    tick(50);
    fork
      send_frame(8'hF0, 1'b0, 1'b1);
      begin
        tick(5 * CPB + CPB / 2);
        resetn = 1'b0;
        tick(3);
        resetn = 1'b1;
        tick(1);
        n_chk++; if ({valid_a, cnt_a, ovf_a, data_a, perr_a, ferr_a} !== 15'd0)
          $display("FAIL midreset_outputs got %h want 0", {valid_a, cnt_a, ovf_a, data_a, perr_a, ferr_a}); else n_pass++;
      end
    join
    exp_a.delete();
    tick(100);
    n_chk++; if (cnt_a !== 3'd0) $display("FAIL midreset_partial got count %0d want 0", cnt_a); else n_pass++;
    rdy = 1'b1;
    send_frame(8'hF0, 1'b0, 1'b1);
    tick(100);
    n_chk++; if (got_a.size() !== 1) $display("FAIL midreset_count got %0d want 1", got_a.size()); else n_pass++;
    n_chk++; if (got_a.size() == 1 && got_a[0] !== 10'h0F0) $display("FAIL midreset_data got %h want 0f0", got_a[0]); else n_pass++;
    got_a.delete(); exp_a.delete();
  endtask

  task automatic test_random();
    bit done;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s); done = 1'b0;
      fork
        begin
          for (int i = 0; i < 8; i++) begin
            send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            tick(20);
          end
          done = 1'b1;
        end
        while (!done) begin
          tick(1);
          rdy = 1'($urandom_range(0, 1));
        end
      join
      rdy = 1'b1;
      tick(200);
    end
    n_chk++; if (got_a.size() !== exp_a.size()) $display("FAIL rand_a_count got %0d want %0d", got_a.size(), exp_a.size()); else n_pass++;
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      n_chk++; if (got_a[i] !== exp_a[i]) $display("FAIL rand_a_entry%0d got %h want %h", i, got_a[i], exp_a[i]); else n_pass++;
    end
    n_chk++; if (got_b.size() !== exp_b.size()) $display("FAIL rand_b_count got %0d want %0d", got_b.size(), exp_b.size()); else n_pass++;
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      n_chk++; if (got_b[i] !== exp_b[i]) $display("FAIL rand_b_entry%0d got %h want %h", i, got_b[i], exp_b[i]); else n_pass++;
    end
    n_chk++; if (ovf_a !== 1'b0 || ovf_b !== 1'b0) $display("FAIL rand_overflow got %b%b want 00", ovf_a, ovf_b); else n_pass++;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; vcyc_a = 0;
    line = 1'b1; sel = 1'b0; rdy = 1'b1; clr = 1'b0; resetn = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_parity();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
